// File: rtl/controle_pilha.sv
// controle_pilha: stack controller for the Pilha array (pointer, flags, address/io/Data sequencing). Optional peek: CONTROLE_PILHA_PEEK_EN.
// Latency: push busy 2 cycles (ready back 2 cycles after request); pop/peek busy 3 cycles, dout/valid arrive with ready.
// Backpressure: push/pop/peek are sampled only while ready=1; requests made while busy are ignored.
module controle_pilha #(
   parameter int Largura_da_pilha = 16,
   parameter int Tamanho_da_pilha = 64,
   parameter int Tamanho_endereco = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
`ifdef CONTROLE_PILHA_PEEK_EN
   input  logic                          peek,
`endif
   input  logic [Largura_da_pilha-1:0]   din,
   output logic [Largura_da_pilha-1:0]   dout,
   output logic                          valid,
   output logic                          ready,
   output logic                          full,
   output logic                          empty,
   output logic                          erro,
   output logic [Tamanho_endereco:0]     sp,
   output logic [Tamanho_endereco-1:0]   Endereco,
   output logic                          io,
   inout  wire  [Largura_da_pilha-1:0]   Data
);

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      ESCRITA = 2'd1,
      LEITURA = 2'd2,
      CAPTURA = 2'd3
   } estado_t;

   localparam logic [Tamanho_endereco:0]   SP_UM    = (Tamanho_endereco+1)'(1);
   localparam logic [Tamanho_endereco:0]   SP_CHEIO = (Tamanho_endereco+1)'(Tamanho_da_pilha);
   localparam logic [Tamanho_endereco-1:0] END_UM   = Tamanho_endereco'(1);

   estado_t                       r_estado;
   estado_t                       w_proximo;

   logic [Largura_da_pilha-1:0]   r_dado;        // word latched at push accept, driven during ESCRITA
   logic [Largura_da_pilha-1:0]   r_dout;
   logic                          r_valid;
   logic                          r_erro;
   logic                          r_full;
   logic                          r_empty;
   logic                          r_decrementa;  // 1 = current read is a pop, 0 = peek
   logic [Tamanho_endereco:0]     r_sp;
   logic [Tamanho_endereco:0]     w_sp_prox;
   logic [Tamanho_endereco-1:0]   r_endereco;

   logic                          w_aceita_push;
   logic                          w_aceita_leitura;
   logic                          w_leitura_pop;
   logic                          w_rejeita;
   logic                          w_io;

   // State register; a synchronous reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_estado <= OCIOSO;
      end else begin
         r_estado <= w_proximo;
      end
   end

   // Next-state and request decode: push beats pop beats peek; losers are dropped without error.
   always_comb begin
      w_proximo        = r_estado;
      w_aceita_push    = 1'b0;
      w_aceita_leitura = 1'b0;
      w_leitura_pop    = 1'b0;
      w_rejeita        = 1'b0;
      w_io             = 1'b0;
      case (r_estado)
         OCIOSO: begin
            if (push) begin
               if (!r_full) begin
                  w_aceita_push = 1'b1;
                  w_proximo     = ESCRITA;
               end else begin
                  w_rejeita = 1'b1;
               end
            end else if (pop) begin
               if (!r_empty) begin
                  w_aceita_leitura = 1'b1;
                  w_leitura_pop    = 1'b1;
                  w_proximo        = LEITURA;
               end else begin
                  w_rejeita = 1'b1;
               end
            end
`ifdef CONTROLE_PILHA_PEEK_EN
            else if (peek) begin
               if (!r_empty) begin
                  w_aceita_leitura = 1'b1;
                  w_proximo        = LEITURA;
               end else begin
                  w_rejeita = 1'b1;
               end
            end
`endif
         end
         ESCRITA: begin
            // Gated by rst so an aborted write never reaches the array.
            w_io      = !rst;
            w_proximo = OCIOSO;
         end
         LEITURA: begin
            w_proximo = CAPTURA;
         end
         CAPTURA: begin
            w_proximo = OCIOSO;
         end
         default: begin
            w_proximo = OCIOSO;
         end
      endcase
   end

   // Stack pointer update: +1 at the end of ESCRITA, -1 at the end of a pop's CAPTURA, saturating at both ends.
   always_comb begin
      w_sp_prox = r_sp;
      if ((r_estado == ESCRITA) && !r_full) begin
         w_sp_prox = r_sp + SP_UM;
      end else if ((r_estado == CAPTURA) && r_decrementa && !r_empty) begin
         w_sp_prox = r_sp - SP_UM;
      end
   end

   // Pointer and flags registered together so full/empty always match sp.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sp    <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_sp    <= w_sp_prox;
         r_full  <= (w_sp_prox == SP_CHEIO);
         r_empty <= (w_sp_prox == '0);
      end
   end

   // Datapath: latch push word and address at accept, capture read data and error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dado       <= '0;
         r_dout       <= '0;
         r_valid      <= 1'b0;
         r_erro       <= 1'b0;
         r_endereco   <= '0;
         r_decrementa <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_aceita_push) begin
            r_dado     <= din;
            r_endereco <= r_sp[Tamanho_endereco-1:0];
         end
         if (w_aceita_leitura) begin
            // Top of stack lives at sp-1; sp is nonzero here, so no wrap.
            r_endereco   <= r_sp[Tamanho_endereco-1:0] - END_UM;
            r_decrementa <= w_leitura_pop;
         end
         if (w_rejeita) begin
            r_erro <= 1'b1;
         end
         if (r_estado == CAPTURA) begin
            r_dout  <= Data;
            r_valid <= 1'b1;
         end
      end
   end

   assign Data     = w_io ? r_dado : {Largura_da_pilha{1'bz}};
   assign io       = w_io;
   assign Endereco = r_endereco;
   assign dout     = r_dout;
   assign valid    = r_valid;
   assign ready    = (r_estado == OCIOSO);
   assign full     = r_full;
   assign empty    = r_empty;
   assign erro     = r_erro;
   assign sp       = r_sp;

endmodule

// File: tb/tb_controle_pilha.sv
// tb_controle_pilha: bench for controle_pilha with a behavioural Pilha array on the Data bus.
// Stack contents modelled as a queue; every operation checked cycle by cycle.
// Stimulus: fixed vector table, hand-written corner sequences, then randomized ops.
module tb_controle_pilha;

   localparam int W = 16;
   localparam int DEPTH = 64;
   localparam int A = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          push = 1'b0;
   logic          pop = 1'b0;
`ifdef CONTROLE_PILHA_PEEK_EN
   logic          peek = 1'b0;
`endif
   logic [W-1:0]  din = '0;
   logic [W-1:0]  dout;
   logic          valid, ready, full, empty, erro, io;
   logic [A:0]    sp;
   logic [A-1:0]  Endereco;
   wire  [W-1:0]  Data;

   controle_pilha dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop),
`ifdef CONTROLE_PILHA_PEEK_EN
      .peek(peek),
`endif
      .din(din), .dout(dout), .valid(valid), .ready(ready), .full(full),
      .empty(empty), .erro(erro), .sp(sp), .Endereco(Endereco), .io(io), .Data(Data)
   );

   always #5 clk = ~clk;

   // Behavioural Pilha: writes on the rising edge while io=1, drives the bus otherwise.
   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] mem_rd;
   assign mem_rd = mem[Endereco];
   assign Data = io ? {W{1'bz}} : mem_rd;
   always @(posedge clk) begin
      if (io) mem[Endereco] <= Data;
   end

   // Reference model state.
   logic [W-1:0] model[$];
   bit           m_erro;
   int           m_addr;
   logic [W-1:0] m_dout;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nome, act, exp, $time);
      end
   endtask

   task automatic do_reset(input int ciclos);
      rst = 1'b1;
      push = 1'b0; pop = 1'b0;
      repeat (ciclos) @(negedge clk);
      model.delete();
      m_erro = 1'b0;
      m_addr = 0;
      m_dout = '0;
      rst = 1'b0;
   endtask

   // One operation, starting at a negedge with the controller idle; ends at the negedge where ready returns.
   task automatic op(input bit p, input bit o, input logic [W-1:0] d, output bit saw_valid);
      int n;
      logic [W-1:0] esperado;
      n = model.size();
      saw_valid = 1'b0;
      chk("ready_before", ready, 1);
      push = p; pop = o; din = d;
      @(negedge clk);
      push = 1'b0; pop = 1'b0;
      if (p && n == DEPTH) begin
         m_erro = 1'b1;
         chk("push_full_ready", ready, 1);
         chk("push_full_erro", erro, 1);
         chk("push_full_sp", sp, n);
         chk("push_full_valid", valid, 0);
         chk("push_full_addr", Endereco, m_addr);
      end else if (p) begin
         chk("escrita_ready", ready, 0);
         chk("escrita_io", io, 1);
         chk("escrita_addr", Endereco, n);
         chk("escrita_data", Data, d);
         chk("escrita_valid", valid, 0);
         @(negedge clk);
         model.push_back(d);
         m_addr = n;
         chk("push_io", io, 0);
         chk("push_ready", ready, 1);
         chk("push_sp", sp, n + 1);
         chk("push_full", full, (n + 1 == DEPTH));
         chk("push_empty", empty, 0);
         chk("push_erro", erro, m_erro);
      end else if (o && n == 0) begin
         m_erro = 1'b1;
         chk("pop_empty_ready", ready, 1);
         chk("pop_empty_erro", erro, 1);
         chk("pop_empty_sp", sp, 0);
         chk("pop_empty_valid", valid, 0);
      end else if (o) begin
         esperado = model.pop_back();
         chk("leitura_ready", ready, 0);
         chk("leitura_io", io, 0);
         chk("leitura_addr", Endereco, n - 1);
         chk("leitura_valid", valid, 0);
         @(negedge clk);
         chk("captura_ready", ready, 0);
         chk("captura_addr", Endereco, n - 1);
         chk("captura_valid", valid, 0);
         @(negedge clk);
         m_addr = n - 1;
         m_dout = esperado;
         saw_valid = valid;
         chk("pop_valid", valid, 1);
         chk("pop_dout", dout, esperado);
         chk("pop_ready", ready, 1);
         chk("pop_sp", sp, n - 1);
         chk("pop_empty", empty, (n - 1 == 0));
         chk("pop_full", full, 0);
         chk("pop_erro", erro, m_erro);
      end else begin
         chk("idle_ready", ready, 1);
         chk("idle_valid", valid, 0);
         chk("idle_sp", sp, n);
         chk("idle_addr", Endereco, m_addr);
         chk("idle_io", io, 0);
      end
   endtask

   typedef struct {
      bit           p;
      bit           o;
      logic [W-1:0] d;
      logic [A:0]   exp_sp;
      bit           exp_valid;
      logic [W-1:0] exp_dout;
      bit           exp_erro;
   } vec_t;

   vec_t tab[5];

   initial begin
      bit sv;
      logic [W-1:0] antigo;
      int r, pct;

      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      tab[0] = '{1'b1, 1'b0, 16'h1234, 7'd1, 1'b0, 16'h0000, 1'b0};
      tab[1] = '{1'b1, 1'b0, 16'hBEEF, 7'd2, 1'b0, 16'h0000, 1'b0};
      tab[2] = '{1'b0, 1'b1, 16'h0000, 7'd1, 1'b1, 16'hBEEF, 1'b0};
      tab[3] = '{1'b0, 1'b1, 16'h0000, 7'd0, 1'b1, 16'h1234, 1'b0};
      tab[4] = '{1'b0, 1'b1, 16'h0000, 7'd0, 1'b0, 16'h1234, 1'b1};

      // Reset values after two reset cycles.
      do_reset(2);
      chk("rst_sp", sp, 0);
      chk("rst_dout", dout, 0);
      chk("rst_valid", valid, 0);
      chk("rst_erro", erro, 0);
      chk("rst_io", io, 0);
      chk("rst_addr", Endereco, 0);
      chk("rst_ready", ready, 1);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);

      // Vector table: push/push/pop/pop/pop-on-empty.
      for (int i = 0; i < 5; i++) begin
         op(tab[i].p, tab[i].o, tab[i].d, sv);
         chk("tab_sp", sp, tab[i].exp_sp);
         chk("tab_valid", sv, tab[i].exp_valid);
         chk("tab_dout", dout, tab[i].exp_dout);
         chk("tab_erro", erro, tab[i].exp_erro);
      end
      do_reset(1);
      chk("rst_clears_erro", erro, 0);

      // Fill to 64, overflow push, drain in reverse.
      for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, W'(16'h1000 + i * 3), sv);
      op(1'b1, 1'b0, 16'hAAAA, sv);
      chk("ovf_full", full, 1);
      chk("ovf_erro", erro, 1);
      chk("ovf_sp", sp, DEPTH);
      for (int i = 0; i < DEPTH; i++) op(1'b0, 1'b1, '0, sv);
      chk("drain_empty", empty, 1);
      chk("drain_last", dout, 16'h1000);

      // push and pop together: push wins, pop dropped silently.
      do_reset(1);
      for (int i = 0; i < 3; i++) op(1'b1, 1'b0, W'(16'h0500 + i), sv);
      op(1'b1, 1'b1, 16'h0042, sv);
      chk("tie_sp", sp, 4);
      chk("tie_valid", sv, 0);
      chk("tie_erro", erro, 0);

      // Reset during LEITURA: no valid, pointer back to 0.
      push = 1'b0; pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
      chk("abort_rd_in_leitura", ready, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_rd_valid", valid, 0);
      chk("abort_rd_sp", sp, 0);
      chk("abort_rd_ready", ready, 1);
      do_reset(1);
      @(negedge clk);
      chk("abort_rd_valid_after", valid, 0);

      // Reset during ESCRITA: io drops in the reset cycle, array untouched.
      antigo = mem[0];
      push = 1'b1; din = ~antigo;
      @(negedge clk);
      push = 1'b0;
      chk("abort_wr_io_before", io, 1);
      rst = 1'b1;
      #1;
      chk("abort_wr_io_rst", io, 0);
      @(negedge clk);
      chk("abort_wr_mem", mem[0], antigo);
      chk("abort_wr_sp", sp, 0);
      do_reset(1);

      // Randomized phases: fill-heavy, drain-heavy, repeat.
      for (int k = 0; k < 400; k++) begin
         r = $urandom_range(0, 99);
         pct = ((k / 100) % 2 == 0) ? 75 : 25;
         if (r < pct) op(1'b1, ($urandom_range(0, 7) == 0), W'($urandom), sv);
         else if (r < 94) op(1'b0, 1'b1, '0, sv);
         else op(1'b0, 1'b0, '0, sv);
      end

`ifdef CONTROLE_PILHA_PEEK_EN
      do_reset(1);
      op(1'b1, 1'b0, 16'h00FF, sv);
      for (int i = 0; i < 2; i++) begin
         peek = 1'b1;
         @(negedge clk);
         peek = 1'b0;
         chk("peek_busy", ready, 0);
         repeat (2) @(negedge clk);
         chk("peek_valid", valid, 1);
         chk("peek_dout", dout, 16'h00FF);
         chk("peek_sp", sp, 1);
      end
      do_reset(1);
      peek = 1'b1;
      @(negedge clk);
      peek = 1'b0;
      chk("peek_empty_erro", erro, 1);
      chk("peek_empty_ready", ready, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
